change_dispenser: RTL

- Downstream neighbour of the coin-totalling stage in the vending machine.
- On a vend or refund request it takes the accumulated amount and the product price, then computes the change or refund.
- It pays that value out one coin at a time to the coin hopper over a valid/ready handshake, largest denomination first (10, 5, 1).
- It tracks an internal stock count per denomination and flags when exact change cannot be paid.

---
 rtl/change_dispenser.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change/refund dispenser: pays out the remaining credit one coin at a time (10, 5, 1) with per-denomination stock.
// Optional hopper timeout is enabled by defining DISPENSE_TIMEOUT_EN.
module change_dispenser #(
  parameter int STOCK_10       = 4,
  parameter int STOCK_5        = 4,
  parameter int STOCK_1        = 9,
  parameter int STOCK_W        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       refund,
  input  logic [4:0] amount_in,
  input  logic [4:0] price,
  input  logic       restock,
  input  logic       coin_out_ready,
  output logic       coin_out_valid,
  output logic [4:0] coin_out_value,
  output logic       busy,
  output logic       done,
  output logic       change_err,
  output logic       insufficient,
  output logic [4:0] shortfall,
  output logic [2:0] stock_empty
);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER, FINISH} state_t;

  localparam int STOCK_MAX = (1 << STOCK_W) - 1;

  function automatic logic [STOCK_W-1:0] load_value(input int p);
    return (p > STOCK_MAX) ? STOCK_W'(STOCK_MAX) : STOCK_W'(p);
  endfunction

  // Index 0 is the largest denomination; selection prefers the lowest index.
  localparam logic [4:0]         DENOM    [3] = '{5'd10, 5'd5, 5'd1};
  localparam logic [STOCK_W-1:0] LOAD_VAL [3] = '{load_value(STOCK_10), load_value(STOCK_5), load_value(STOCK_1)};

  state_t             state_reg, state_next;
  logic [4:0]         remaining_reg, remaining_next;
  logic [STOCK_W-1:0] stock_reg [3];
  logic [STOCK_W-1:0] stock_next [3];
  logic [1:0]         sel_reg, sel_next;
  logic               valid_reg, valid_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               insufficient_reg, insufficient_next;
  logic [4:0]         shortfall_reg, shortfall_next;
  logic [1:0]         pick;
  logic               pick_ok;

`ifdef DISPENSE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count_reg, count_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      remaining_reg    <= '0;
      stock_reg        <= LOAD_VAL;
      sel_reg          <= '0;
      valid_reg        <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
      insufficient_reg <= 1'b0;
      shortfall_reg    <= '0;
`ifdef DISPENSE_TIMEOUT_EN
      count_reg        <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      remaining_reg    <= remaining_next;
      stock_reg        <= stock_next;
      sel_reg          <= sel_next;
      valid_reg        <= valid_next;
      done_reg         <= done_next;
      err_reg          <= err_next;
      insufficient_reg <= insufficient_next;
      shortfall_reg    <= shortfall_next;
`ifdef DISPENSE_TIMEOUT_EN
      count_reg        <= count_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    remaining_next    = remaining_reg;
    stock_next        = stock_reg;
    sel_next          = sel_reg;
    valid_next        = valid_reg;
    done_next         = 1'b0;
    err_next          = 1'b0;
    insufficient_next = 1'b0;
    shortfall_next    = shortfall_reg;
    pick              = 2'd0;
    pick_ok           = 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
    count_next        = count_reg;
`endif

    // Scan smallest to largest so the largest payable denomination wins.
    for (int i = 2; i >= 0; i--) begin
      if (DENOM[i] <= remaining_reg && stock_reg[i] != '0) begin
        pick    = 2'(i);
        pick_ok = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          shortfall_next = '0;
          if (refund) begin
            remaining_next = amount_in;
            state_next     = SELECT;
          end else if (amount_in >= price) begin
            remaining_next = amount_in - price;
            state_next     = SELECT;
          end else begin
            insufficient_next = 1'b1;
          end
        end else if (restock) begin
          stock_next = LOAD_VAL;
        end
      end
      SELECT: begin
        if (pick_ok) begin
          sel_next   = pick;
          valid_next = 1'b1;
          state_next = OFFER;
`ifdef DISPENSE_TIMEOUT_EN
          count_next = '0;
`endif
        end else begin
          state_next     = FINISH;
          done_next      = 1'b1;
          err_next       = (remaining_reg != 5'd0);
          shortfall_next = remaining_reg;
        end
      end
      OFFER: begin
        if (coin_out_ready) begin
          remaining_next      = remaining_reg - DENOM[sel_reg];
          stock_next[sel_reg] = stock_reg[sel_reg] - STOCK_W'(1);
          valid_next          = 1'b0;
          state_next          = SELECT;
`ifdef DISPENSE_TIMEOUT_EN
        end else if (count_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          valid_next     = 1'b0;
          state_next     = FINISH;
          done_next      = 1'b1;
          err_next       = 1'b1;
          shortfall_next = remaining_reg;
        end else begin
          count_next = count_reg + CW'(1);
`endif
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign coin_out_valid = valid_reg;
  assign coin_out_value = valid_reg ? DENOM[sel_reg] : 5'd0;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign change_err     = err_reg;
  assign insufficient   = insufficient_reg;
  assign shortfall      = shortfall_reg;

  // stock_empty bit 2 is the 10-coin counter, bit 0 the 1-coin counter.
  for (genvar gi = 0; gi < 3; gi++) begin : g_empty
    assign stock_empty[2-gi] = (stock_reg[gi] == '0);
  end

endmodule
